// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the next-PC sequencer: PC-source select codes,
// FSM state encoding and the default PC width.
package pc_ctrl_pkg;

    localparam int DEFAULT_PC_W = 7;

    localparam logic [1:0] PCSRC_SEQ = 2'd0;
    localparam logic [1:0] PCSRC_BR  = 2'd1;
    localparam logic [1:0] PCSRC_JR  = 2'd2;
    localparam logic [1:0] PCSRC_J   = 2'd3;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

endpackage

// File: rtl/pc_redirect_ctrl_next_pc_sel.sv
// Next-PC target select: 4:1 mux indexed by the PC-source code.
module next_pc_sel
    import pc_ctrl_pkg::*;
#(
    parameter int PC_W = DEFAULT_PC_W
) (
    input  logic [1:0]      pcsrc,
    input  logic [PC_W-1:0] pc_plus1,
    input  logic [PC_W-1:0] pc_branch,
    input  logic [PC_W-1:0] jr_target,
    input  logic [PC_W-1:0] jump_target,
    output logic [PC_W-1:0] next_pc
);

    // Pick the next Fetch PC from the resolved source code.
    always_comb begin
        next_pc = pc_plus1;
        case (pcsrc)
            PCSRC_BR: next_pc = pc_branch;
            PCSRC_JR: next_pc = jr_target;
            PCSRC_J:  next_pc = jump_target;
            default:  next_pc = pc_plus1;
        endcase
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Next-PC sequencer: owns the Fetch PC, resolves branch/JR/J in Decode,
// stalls F/D on operand hazards and flushes the wrong-path Fetch slot.
// Optional feature: define REDIRECT_CNT_EN to add the redirect_cnt output.
module pc_redirect_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int              PC_W      = DEFAULT_PC_W,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              MAX_STALL = 3,
    parameter int              CNT_W     = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_en,
    input  logic            branch_d,
    input  logic            branch_taken_d,
    input  logic            jr_d,
    input  logic            jump_d,
    input  logic            operand_hazard_d,
    input  logic [PC_W-1:0] pc_branch_d,
    input  logic [PC_W-1:0] jr_target_d,
    input  logic [PC_W-1:0] jump_target_d,
    output logic [PC_W-1:0] pc_f,
    output logic [1:0]      pcsrc_d,
    output logic            stall_f,
    output logic            stall_d,
    output logic            flush_d,
    output logic            hazard_err
`ifdef REDIRECT_CNT_EN
    ,
    output logic [CNT_W-1:0] redirect_cnt
`endif
);

    localparam int SCNT_W = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);

    state_t            state;
    logic [SCNT_W-1:0] stall_cnt;
    logic [PC_W-1:0]   pc_plus1;
    logic [PC_W-1:0]   next_pc;
    logic              hz_stall;
    logic              advance;

    assign pc_plus1 = pc_f + 1'b1;

    next_pc_sel #(
        .PC_W(PC_W)
    ) u_next_pc_sel (
        .pcsrc      (pcsrc_d),
        .pc_plus1   (pc_plus1),
        .pc_branch  (pc_branch_d),
        .jr_target  (jr_target_d),
        .jump_target(jump_target_d),
        .next_pc    (next_pc)
    );

    // Same-cycle Decode resolution: select, stall and flush from state and inputs.
    always_comb begin
        pcsrc_d  = PCSRC_SEQ;
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        flush_d  = 1'b0;
        hz_stall = 1'b0;
        advance  = 1'b0;
        if (rst) begin
            flush_d = 1'b1;
        end else if (state == BOOT) begin
            flush_d = 1'b1;
            advance = 1'b1;
        end else if (!fetch_en) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
        end else if ((branch_d | jr_d) & operand_hazard_d) begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            hz_stall = 1'b1;
        end else begin
            advance = 1'b1;
            if (jr_d)
                pcsrc_d = PCSRC_JR;
            else if (jump_d)
                pcsrc_d = PCSRC_J;
            else if (branch_d & branch_taken_d)
                pcsrc_d = PCSRC_BR;
            flush_d = (pcsrc_d != PCSRC_SEQ);
        end
    end

    // FSM, Fetch PC register, stall-run counter and sticky hazard error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BOOT;
            pc_f       <= RESET_PC;
            stall_cnt  <= '0;
            hazard_err <= 1'b0;
        end else if (state == BOOT) begin
            pc_f  <= next_pc;
            state <= RUN;
        end else if (fetch_en) begin
            if (hz_stall) begin
                state <= STALL;
                if (int'(stall_cnt) < MAX_STALL)
                    stall_cnt <= stall_cnt + 1'b1;
                if (int'(stall_cnt) + 1 >= MAX_STALL)
                    hazard_err <= 1'b1;
            end else begin
                state     <= RUN;
                pc_f      <= next_pc;
                stall_cnt <= '0;
            end
        end
    end

`ifdef REDIRECT_CNT_EN
    // Saturating count of taken redirects (PC not sequential, no stall).
    always_ff @(posedge clk) begin
        if (rst)
            redirect_cnt <= '0;
        else if (advance && (pcsrc_d != PCSRC_SEQ) && (redirect_cnt != '1))
            redirect_cnt <= redirect_cnt + 1'b1;
    end
`else
    // CNT_W only sizes the optional counter; keep it referenced here.
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: directed steps followed by a
// randomized phase, compared against a behavioural model of the sequencer.
module tb_pc_redirect_ctrl;

    localparam int PC_W      = 7;
    localparam int MAX_STALL = 3;
    localparam int CNT_W     = 16;
    localparam int PC_MOD    = 128;
    localparam int CNT_MAX   = 65535;

    logic            clk;
    logic            rst;
    logic            fetch_en;
    logic            branch_d;
    logic            branch_taken_d;
    logic            jr_d;
    logic            jump_d;
    logic            operand_hazard_d;
    logic [PC_W-1:0] pc_branch_d;
    logic [PC_W-1:0] jr_target_d;
    logic [PC_W-1:0] jump_target_d;
    logic [PC_W-1:0] pc_f;
    logic [1:0]      pcsrc_d;
    logic            stall_f;
    logic            stall_d;
    logic            flush_d;
    logic            hazard_err;
`ifdef REDIRECT_CNT_EN
    logic [CNT_W-1:0] redirect_cnt;
`endif

    pc_redirect_ctrl #(
        .PC_W     (PC_W),
        .RESET_PC (7'd0),
        .MAX_STALL(MAX_STALL),
        .CNT_W    (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_en        (fetch_en),
        .branch_d        (branch_d),
        .branch_taken_d  (branch_taken_d),
        .jr_d            (jr_d),
        .jump_d          (jump_d),
        .operand_hazard_d(operand_hazard_d),
        .pc_branch_d     (pc_branch_d),
        .jr_target_d     (jr_target_d),
        .jump_target_d   (jump_target_d),
        .pc_f            (pc_f),
        .pcsrc_d         (pcsrc_d),
        .stall_f         (stall_f),
        .stall_d         (stall_d),
        .flush_d         (flush_d),
        .hazard_err      (hazard_err)
`ifdef REDIRECT_CNT_EN
        ,
        .redirect_cnt    (redirect_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    int m_pc;
    bit m_booting;
    int m_run;
    bit m_err;
    int m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One cycle: drive inputs, check mid-cycle against the model, clock, update model.
    task automatic step(input string tag, input bit r, input bit fen, input bit br,
                        input bit tk, input bit jr, input bit jp, input bit hz,
                        input int pb, input int jt, input int jpt);
        int  e_src;
        bit  e_stall;
        bit  e_flush;
        bit  hold;
        rst = r; fetch_en = fen; branch_d = br; branch_taken_d = tk;
        jr_d = jr; jump_d = jp; operand_hazard_d = hz;
        pc_branch_d = 7'(pb); jr_target_d = 7'(jt); jump_target_d = 7'(jpt);
        #3;
        e_src = 0; e_stall = 0; e_flush = 0; hold = 0;
        if (r || m_booting) begin
            e_flush = 1;
        end else if (!fen) begin
            e_stall = 1; hold = 1;
        end else if ((br || jr) && hz) begin
            e_stall = 1;
        end else begin
            e_src = jr ? 2 : (jp ? 3 : ((br && tk) ? 1 : 0));
            e_flush = (e_src != 0);
        end
        check({tag, ".pc_f"},       32'(pc_f),       32'(m_pc));
        check({tag, ".pcsrc_d"},    32'(pcsrc_d),    32'(e_src));
        check({tag, ".stall_f"},    32'(stall_f),    32'(e_stall));
        check({tag, ".stall_d"},    32'(stall_d),    32'(e_stall));
        check({tag, ".flush_d"},    32'(flush_d),    32'(e_flush));
        check({tag, ".hazard_err"}, 32'(hazard_err), 32'(m_err));
`ifdef REDIRECT_CNT_EN
        check({tag, ".redirect_cnt"}, 32'(redirect_cnt), 32'(m_cnt));
`endif
        @(posedge clk);
        #1;
        if (r) begin
            m_pc = 0; m_booting = 1; m_run = 0; m_err = 0; m_cnt = 0;
        end else if (m_booting) begin
            m_pc = (m_pc + 1) % PC_MOD; m_booting = 0;
        end else if (hold) begin
            // frozen
        end else if (e_stall) begin
            if (m_run < MAX_STALL) m_run++;
            if (m_run >= MAX_STALL) m_err = 1;
        end else begin
            case (e_src)
                1: m_pc = pb;
                2: m_pc = jt;
                3: m_pc = jpt;
                default: m_pc = (m_pc + 1) % PC_MOD;
            endcase
            m_run = 0;
            if (e_src != 0 && m_cnt < CNT_MAX) m_cnt++;
        end
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; fetch_en = 1; branch_d = 0; branch_taken_d = 0; jr_d = 0; jump_d = 0;
        operand_hazard_d = 0; pc_branch_d = '0; jr_target_d = '0; jump_target_d = '0;
        @(posedge clk);
        #1;
        m_pc = 0; m_booting = 1; m_run = 0; m_err = 0; m_cnt = 0;

        // 1 reset held, boot, sequential fetch
        step("rst0", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rst1", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("boot", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("boot.pc_after", 32'(pc_f), 32'd1);
        idle("seq1"); idle("seq2"); idle("seq3"); idle("seq4");
        check("seq.pc_is_5", 32'(pc_f), 32'd5);

        // 2 branch taken then not taken
        step("br_taken", 0, 1, 1, 1, 0, 0, 0, 20, 0, 0);
        check("br_taken.next_pc", 32'(pc_f), 32'd20);
        step("br_ntaken", 0, 1, 1, 0, 0, 0, 0, 40, 0, 0);
        check("br_ntaken.next_pc", 32'(pc_f), 32'd21);

        // 3 JR with a 2-cycle hazard
        step("jr_hz1", 0, 1, 0, 0, 1, 0, 1, 0, 64, 0);
        step("jr_hz2", 0, 1, 0, 0, 1, 0, 1, 0, 64, 0);
        step("jr_go",  0, 1, 0, 0, 1, 0, 0, 0, 64, 0);
        check("jr_go.next_pc", 32'(pc_f), 32'd64);

        // 4 wrap and priority
        step("j_127", 0, 1, 0, 0, 0, 1, 1, 0, 0, 127);
        idle("wrap");
        check("wrap.pc_is_0", 32'(pc_f), 32'd0);
        step("prio", 0, 1, 0, 0, 1, 1, 0, 0, 9, 33);
        check("prio.next_pc", 32'(pc_f), 32'd9);

        // 5 hazard timeout, sticky error
        for (int i = 0; i < 4; i++) step("br_hz", 0, 1, 1, 1, 0, 0, 1, 50, 0, 0);
        check("timeout.err", 32'(hazard_err), 32'd1);
        idle("sticky1");
        step("sticky2", 0, 1, 1, 1, 0, 0, 0, 50, 0, 0);

        // 6 freeze, then three redirects
        step("freeze1", 0, 0, 0, 0, 0, 1, 0, 0, 0, 70);
        step("freeze2", 0, 0, 0, 0, 0, 1, 0, 0, 0, 70);
        step("redir1", 0, 1, 0, 0, 0, 1, 0, 0, 0, 70);
        step("redir2", 0, 1, 1, 1, 0, 0, 0, 80, 0, 0);
        step("redir3", 0, 1, 0, 0, 1, 0, 0, 0, 90, 0);
        idle("post_redir");
        step("rst_clear", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("reboot", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // randomized phase
        for (int i = 0; i < 300; i++) begin
            step("rand",
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 9) != 0),
                 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) < 4),
                 int'($urandom_range(0, 127)), int'($urandom_range(0, 127)),
                 int'($urandom_range(0, 127)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
